// File: rtl/controle_somador_serial.sv
// Bit-serial adder: one full-adder cell processes operands LSB first, one bit per clock.
// Optional build macro SERIAL_SUB_EN adds a 'sub' input that turns the operation into a - b.

module somador_completo (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module controle_somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_sub;
    logic             w_sub_in;
    logic             w_accept;
    logic             w_last;
    logic             w_b_bit;
    logic             w_s;
    logic             w_c;

`ifdef SERIAL_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
    // Subtraction is a + ~b + 1: invert B bits here, the +1 comes from the seeded carry.
    assign w_b_bit  = r_b_sr[0] ^ r_sub;

    somador_completo u_fa (
        .i_a (r_a_sr[0]),
        .i_b (w_b_bit),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_sub   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_cnt   <= '0;
            r_sub   <= w_sub_in;
            r_carry <= w_sub_in ? 1'b1 : carry_in;
        end else if (r_state == S_RUN) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            // On the MSB, r_carry still holds the carry into that bit.
            if (w_last) begin
                r_sum  <= {w_s, r_res[WIDTH-1:1]};
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_controle_somador_serial.sv
// Directed self-checking bench for controle_somador_serial (WIDTH=8).
// Honours SERIAL_SUB_EN to exercise the subtract mode when it is built in.

module tb_controle_somador_serial;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       carry_in = 1'b0;
`ifdef SERIAL_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    controle_somador_serial #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        @(negedge clock);
        a = ta;
        b = tb_v;
        carry_in = tc;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen, bounded at 20.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (n < 20 && !done) begin
            @(posedge clock);
            #1 n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        start_op(ta, tb_v, tc);
        check({tag, "_busy_acc"}, busy, 1'b1);
        wait_done(0, n);
        check({tag, "_latency"}, n, 8);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        int busy_cycles;
        int done_cnt;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", carry_out, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // 0x5A + 0x3C with explicit busy-length measurement.
        start_op(8'h5A, 8'h3C, 1'b0);
        busy_cycles = busy ? 1 : 0;
        n = 0;
        while (n < 20 && !done) begin
            @(posedge clock);
            #1 n++;
            if (busy) busy_cycles++;
            if (n == 4) check("t1_sum_stable", sum, 8'h00);
        end
        check("t1_latency", n, 8);
        check("t1_sum", sum, 8'h96);
        check("t1_cout", carry_out, 1'b0);
        check("t1_ovf", overflow, 1'b1);
        @(posedge clock);
        #1;
        if (busy) busy_cycles++;
        check("t1_busy_cycles", busy_cycles, 9);
        check("t1_done_low", done, 1'b0);

        do_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("t2b", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op("t3a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("t3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start requests during RUN and DONE must be ignored.
        start_op(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("t4_sum_stable", sum, 8'h00);
        a = 8'hFF;
        b = 8'hFF;
        carry_in = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(3, n);
        check("t4_latency", n, 8);
        check("t4_sum", sum, 8'h46);
        check("t4_cout", carry_out, 1'b0);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("t4_busy_after", busy, 1'b0);
        done_cnt = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done) done_cnt++;
        end
        check("t4_extra_done", done_cnt, 0);
        check("t4_sum_held", sum, 8'h46);

        // Reset in the 4th RUN cycle discards the operation.
        start_op(8'h55, 8'h0F, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_sum", sum, 8'h00);
        check("t5_done", done, 1'b0);
        done_cnt = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done) done_cnt++;
        end
        check("t5_no_done", done_cnt, 0);
        do_op("t5_fresh", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
        sub = 1'b1;
        do_op("t6a", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        do_op("t6b", 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0);
        sub = 1'b0;
        do_op("t6c", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
